mem_subsys: RTL and testbench

MEM_SUBSYS -- requirements
Module: mem_subsys

---
 rtl/mem_subsys.sv | 165 ++++++++++++++++
 tb/tb_mem_subsys.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_subsys.sv
// Memory subsystem: RAM, tilemap, framebuffer, memory-mapped IO and a UART TX FIFO.
// Two 2-cycle read ports plus a 2-cycle tile-based display pipeline.
module mem_subsys #(
    parameter int          DATA_W            = 16,
    parameter logic [15:0] TILEMAP_START     = 16'hC000,
    parameter logic [15:0] FRAMEBUFFER_START = 16'hE000,
    parameter logic [15:0] IO_START          = 16'hF000,
    parameter int          FB_COLS_LOG2      = 7,
    parameter int          UART_FIFO_DEPTH   = 16,
    parameter string       RAM_INIT          = "",
    parameter string       TILE_INIT         = ""
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [15:0]       raddr0,
    output logic [DATA_W-1:0] rdata0,
    input  logic              ren,
    input  logic [15:0]       raddr1,
    output logic [DATA_W-1:0] rdata1,
    input  logic              wen,
    input  logic [15:0]       waddr,
    input  logic [DATA_W-1:0] wdata,
    output logic              ps2_ren,
    input  logic [15:0]       ps2_data_in,
    input  logic [9:0]        pixel_x_in,
    input  logic [9:0]        pixel_y_in,
    output logic [11:0]       pixel,
    output logic [7:0]        uart_tx_data,
    output logic              uart_tx_valid,
    input  logic              uart_tx_ready
);
    localparam int RAM_WORDS  = int'(TILEMAP_START);
    localparam int TILE_WORDS = int'(FRAMEBUFFER_START) - int'(TILEMAP_START);
    localparam int FB_WORDS   = int'(IO_START) - int'(FRAMEBUFFER_START);
    localparam int RAM_AW     = $clog2(RAM_WORDS);
    localparam int TILE_AW    = $clog2(TILE_WORDS);
    localparam int FB_AW      = $clog2(FB_WORDS);
    localparam int PTR_W      = $clog2(UART_FIFO_DEPTH);
    localparam int CNT_W      = PTR_W + 1;

    localparam logic [15:0] A_PS2     = 16'hFFFF;
    localparam logic [15:0] A_VSCROLL = 16'hFFFE;
    localparam logic [15:0] A_HSCROLL = 16'hFFFD;
    localparam logic [15:0] A_SCALE   = 16'hFFFC;
    localparam logic [15:0] A_STATUS  = 16'hFFFB;

    logic [DATA_W-1:0] ram      [RAM_WORDS];
    logic [DATA_W-1:0] tile_mem [TILE_WORDS];
    logic [DATA_W-1:0] fb_mem   [FB_WORDS];
    logic [7:0]        fifo     [UART_FIFO_DEPTH];

    logic [DATA_W-1:0] scale, hscroll, vscroll;
    logic [DATA_W-1:0] rd0_q, rd1_q;
    logic              ps2_q, ovf;
    logic [CNT_W-1:0]  count;
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [7:0]        cnt_sat;
    logic [15:0]       status;
    logic              push_req, full, push, pop, ovf_evt, stat_clr;

    assign full          = (count == CNT_W'(UART_FIFO_DEPTH));
    assign push_req      = wen && (waddr == IO_START);
    assign push          = push_req && !full;
    assign ovf_evt       = push_req && full;
    assign uart_tx_valid = (count != '0);
    assign pop           = uart_tx_valid && uart_tx_ready;
    assign stat_clr      = ren && (raddr1 == A_STATUS);
    assign uart_tx_data  = uart_tx_valid ? fifo[rd_ptr] : 8'h00;
    assign cnt_sat       = (32'(count) > 32'd255) ? 8'hFF : 8'(count);
    assign status        = {ovf, 7'b0, cnt_sat};

    function automatic logic [DATA_W-1:0] read_word(input logic [15:0] a);
        logic [DATA_W-1:0] v;
        v = '0;
        if (a < TILEMAP_START)          v = ram[RAM_AW'(a)];
        else if (a < FRAMEBUFFER_START) v = tile_mem[TILE_AW'(a - TILEMAP_START)];
        else if (a < IO_START)          v = fb_mem[FB_AW'(a - FRAMEBUFFER_START)];
        else begin
            case (a)
                A_PS2:     v = DATA_W'(ps2_data_in);
                A_VSCROLL: v = vscroll;
                A_HSCROLL: v = hscroll;
                A_SCALE:   v = scale;
                A_STATUS:  v = DATA_W'(status);
                default:   v = '0;
            endcase
        end
        return v;
    endfunction

    // Display stage-1 address: scaled, scrolled coordinates into framebuffer
    logic [3:0]  sx, sy;
    logic [9:0]  xs, ys, px, py;
    logic [15:0] fa;
    logic [FB_AW-1:0] fb_idx;
    always_comb begin
        sx     = scale[3:0];
        sy     = scale[7:4];
        xs     = (sx >= 4'd10) ? 10'd0 : (pixel_x_in >> sx);
        ys     = (sy >= 4'd10) ? 10'd0 : (pixel_y_in >> sy);
        px     = xs + hscroll[9:0];
        py     = ys + vscroll[9:0];
        fa     = 16'(px[9:3]) + (16'(py[9:3]) << FB_COLS_LOG2);
        fb_idx = FB_AW'(fa >> 1);
    end

    logic [DATA_W-1:0] disp_word_q;
    logic              disp_hi_q;
    logic [2:0]        disp_row_q, disp_col_q;
    logic [7:0]        tile;
    assign tile = disp_hi_q ? disp_word_q[15:8] : disp_word_q[7:0];

    always_ff @(posedge clk) begin
        if (wen) begin
            if (waddr < TILEMAP_START)          ram[RAM_AW'(waddr)] <= wdata;
            else if (waddr < FRAMEBUFFER_START) tile_mem[TILE_AW'(waddr - TILEMAP_START)] <= wdata;
            else if (waddr < IO_START)          fb_mem[FB_AW'(waddr - FRAMEBUFFER_START)] <= wdata;
        end
        if (push) fifo[wr_ptr] <= wdata[7:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd0_q       <= '0;
            rd1_q       <= '0;
            rdata0      <= '0;
            rdata1      <= '0;
            ps2_q       <= 1'b0;
            ps2_ren     <= 1'b0;
            scale       <= '0;
            hscroll     <= '0;
            vscroll     <= '0;
            ovf         <= 1'b0;
            count       <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            disp_word_q <= '0;
            disp_hi_q   <= 1'b0;
            disp_row_q  <= '0;
            disp_col_q  <= '0;
            pixel       <= '0;
        end else begin
            rd0_q   <= read_word(raddr0);
            rd1_q   <= read_word(raddr1);
            rdata0  <= rd0_q;
            rdata1  <= rd1_q;
            ps2_q   <= ren && (raddr1 == A_PS2);
            ps2_ren <= ps2_q;
            if (wen && waddr == A_SCALE)   scale   <= wdata;
            if (wen && waddr == A_HSCROLL) hscroll <= wdata;
            if (wen && waddr == A_VSCROLL) vscroll <= wdata;
            // An overflow at the same edge as a status read wins over the clear
            if (ovf_evt)       ovf <= 1'b1;
            else if (stat_clr) ovf <= 1'b0;
            count <= count + CNT_W'(push) - CNT_W'(pop);
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            disp_word_q <= fb_mem[fb_idx];
            disp_hi_q   <= fa[0];
            disp_row_q  <= py[2:0];
            disp_col_q  <= px[2:0];
            pixel       <= tile_mem[TILE_AW'({tile, disp_row_q, disp_col_q})][11:0];
        end
    end
endmodule

// File: tb/tb_mem_subsys.sv
// Directed self-checking bench for mem_subsys: read ports, IO map, display path, UART FIFO, PS2, reset.
module tb_mem_subsys;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] raddr0 = '0, raddr1 = '0, waddr = '0, wdata = '0, ps2_data_in = '0;
    logic        ren = 1'b0, wen = 1'b0, uart_tx_ready = 1'b0;
    logic [9:0]  pixel_x_in = '0, pixel_y_in = '0;
    logic [15:0] rdata0, rdata1;
    logic        ps2_ren, uart_tx_valid;
    logic [11:0] pixel;
    logic [7:0]  uart_tx_data;

    int checks = 0;
    int errors = 0;

    mem_subsys dut (
        .clk(clk), .rst_n(rst_n),
        .raddr0(raddr0), .rdata0(rdata0),
        .ren(ren), .raddr1(raddr1), .rdata1(rdata1),
        .wen(wen), .waddr(waddr), .wdata(wdata),
        .ps2_ren(ps2_ren), .ps2_data_in(ps2_data_in),
        .pixel_x_in(pixel_x_in), .pixel_y_in(pixel_y_in), .pixel(pixel),
        .uart_tx_data(uart_tx_data), .uart_tx_valid(uart_tx_valid), .uart_tx_ready(uart_tx_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout reached");
        $fatal(1);
    end

    task automatic do_write(input logic [15:0] a, input logic [15:0] d);
        @(negedge clk); wen = 1'b1; waddr = a; wdata = d;
        @(negedge clk); wen = 1'b0;
    endtask

    task automatic read0(input logic [15:0] a, output logic [15:0] d);
        @(negedge clk); raddr0 = a;
        @(negedge clk);
        @(negedge clk); d = rdata0;
    endtask

    task automatic read1(input logic [15:0] a, output logic [15:0] d);
        @(negedge clk); raddr1 = a; ren = 1'b0;
        @(negedge clk);
        @(negedge clk); d = rdata1;
    endtask

    task automatic read_clr(output logic [15:0] d);
        @(negedge clk); raddr1 = 16'hFFFB; ren = 1'b1;
        @(negedge clk); ren = 1'b0;
        @(negedge clk); d = rdata1;
    endtask

    task automatic show(input logic [9:0] x, input logic [9:0] y, output logic [11:0] p);
        @(negedge clk); pixel_x_in = x; pixel_y_in = y;
        @(negedge clk);
        @(negedge clk); p = pixel;
    endtask

    task automatic test_reset;
        logic [15:0] v;
        repeat (3) @(negedge clk);
        checks++; if (rdata0 !== 16'h0) begin errors++; $display("FAIL rst_rdata0 got %h exp 0000", rdata0); end
        checks++; if (rdata1 !== 16'h0) begin errors++; $display("FAIL rst_rdata1 got %h exp 0000", rdata1); end
        checks++; if (pixel !== 12'h0) begin errors++; $display("FAIL rst_pixel got %h exp 000", pixel); end
        checks++; if (ps2_ren !== 1'b0) begin errors++; $display("FAIL rst_ps2_ren got %b exp 0", ps2_ren); end
        checks++; if (uart_tx_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", uart_tx_valid); end
        checks++; if (uart_tx_data !== 8'h0) begin errors++; $display("FAIL rst_txdata got %h exp 00", uart_tx_data); end
        @(negedge clk); rst_n = 1'b1;
        read1(16'hFFFB, v);
        checks++; if (v !== 16'h0000) begin errors++; $display("FAIL rst_status got %h exp 0000", v); end
    endtask

    task automatic test_ram;
        logic [15:0] v;
        do_write(16'h0010, 16'h1111);
        @(negedge clk); wen = 1'b1; waddr = 16'h0010; wdata = 16'hABCD; raddr0 = 16'h0010;
        @(negedge clk); wen = 1'b0;
        @(negedge clk);
        checks++; if (rdata0 !== 16'h1111) begin errors++; $display("FAIL ram_same_edge got %h exp 1111", rdata0); end
        @(negedge clk);
        checks++; if (rdata0 !== 16'hABCD) begin errors++; $display("FAIL ram_next_edge got %h exp abcd", rdata0); end
        do_write(16'h0000, 16'h0BAD);
        do_write(16'hC000, 16'h7777);
        do_write(16'hC005, 16'h1234);
        do_write(16'hE001, 16'h5678);
        do_write(16'hFFF0, 16'h9999);
        read0(16'h0000, v);
        checks++; if (v !== 16'h0BAD) begin errors++; $display("FAIL ram0 got %h exp 0bad", v); end
        read1(16'hC000, v);
        checks++; if (v !== 16'h7777) begin errors++; $display("FAIL tile0 got %h exp 7777", v); end
        read0(16'hC005, v);
        checks++; if (v !== 16'h1234) begin errors++; $display("FAIL tile5 got %h exp 1234", v); end
        read1(16'hE001, v);
        checks++; if (v !== 16'h5678) begin errors++; $display("FAIL fb1 got %h exp 5678", v); end
        read0(16'hFFF0, v);
        checks++; if (v !== 16'h0000) begin errors++; $display("FAIL io_unmapped got %h exp 0000", v); end
        read0(16'hF000, v);
        checks++; if (v !== 16'h0000) begin errors++; $display("FAIL uart_tx_read got %h exp 0000", v); end
        @(negedge clk); wen = 1'b1; waddr = 16'hFFFD; wdata = 16'h0123; raddr0 = 16'hFFFD;
        @(negedge clk); wen = 1'b0;
        @(negedge clk);
        checks++; if (rdata0 !== 16'h0000) begin errors++; $display("FAIL hscroll_same_edge got %h exp 0000", rdata0); end
        @(negedge clk);
        checks++; if (rdata0 !== 16'h0123) begin errors++; $display("FAIL hscroll_next_edge got %h exp 0123", rdata0); end
        do_write(16'hFFFD, 16'h0000);
    endtask

    task automatic test_display;
        logic [11:0] p;
        do_write(16'hC045, 16'h0F0A);
        do_write(16'hE000, 16'h0100);
        do_write(16'hC001, 16'h0DEF);
        do_write(16'hC00D, 16'h0555);
        show(10'd5, 10'd0, p);
        checks++; if (p !== 12'h234) begin errors++; $display("FAIL pix_tile0 got %h exp 234", p); end
        show(10'd13, 10'd0, p);
        checks++; if (p !== 12'hF0A) begin errors++; $display("FAIL pix_tile1 got %h exp f0a", p); end
        do_write(16'hFFFD, 16'h03FF);
        do_write(16'hFFFC, 16'h0011);
        show(10'd4, 10'd0, p);
        checks++; if (p !== 12'hDEF) begin errors++; $display("FAIL pix_scroll_wrap got %h exp def", p); end
        do_write(16'hFFFD, 16'h0000);
        do_write(16'hFFFC, 16'h000A);
        show(10'd1000, 10'd0, p);
        checks++; if (p !== 12'h777) begin errors++; $display("FAIL pix_shift10 got %h exp 777", p); end
        do_write(16'hFFFC, 16'h0000);
        do_write(16'hFFFE, 16'h0001);
        show(10'd5, 10'd0, p);
        checks++; if (p !== 12'h555) begin errors++; $display("FAIL pix_vscroll got %h exp 555", p); end
        do_write(16'hFFFE, 16'h0000);
    endtask

    task automatic test_uart;
        logic [15:0] v;
        uart_tx_ready = 1'b0;
        for (int i = 0; i < 17; i++) do_write(16'hF000, 16'h0010 + 16'(i));
        read1(16'hFFFB, v);
        checks++; if (v !== 16'h8010) begin errors++; $display("FAIL status_full got %h exp 8010", v); end
        checks++; if (uart_tx_data !== 8'h10 || uart_tx_valid !== 1'b1) begin errors++; $display("FAIL head_full got %h/%b exp 10/1", uart_tx_data, uart_tx_valid); end
        read_clr(v);
        checks++; if (v !== 16'h8010) begin errors++; $display("FAIL status_clr_read got %h exp 8010", v); end
        read1(16'hFFFB, v);
        checks++; if (v !== 16'h0010) begin errors++; $display("FAIL status_after_clr got %h exp 0010", v); end
        @(negedge clk); uart_tx_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            checks++; if (uart_tx_valid !== 1'b1 || uart_tx_data !== 8'(8'h10 + i)) begin errors++; $display("FAIL drain_%0d got %h/%b exp %h/1", i, uart_tx_data, uart_tx_valid, 8'(8'h10 + i)); end
            @(negedge clk);
        end
        checks++; if (uart_tx_valid !== 1'b0) begin errors++; $display("FAIL drain_empty got %b exp 0", uart_tx_valid); end
        uart_tx_ready = 1'b0;

        do_write(16'hF000, 16'h00A1);
        do_write(16'hF000, 16'h00A2);
        @(negedge clk); wen = 1'b1; waddr = 16'hF000; wdata = 16'h00A3; uart_tx_ready = 1'b1;
        @(negedge clk); wen = 1'b0; uart_tx_ready = 1'b0;
        checks++; if (uart_tx_data !== 8'hA2) begin errors++; $display("FAIL pushpop_head got %h exp a2", uart_tx_data); end
        read1(16'hFFFB, v);
        checks++; if (v !== 16'h0002) begin errors++; $display("FAIL pushpop_count got %h exp 0002", v); end
        @(negedge clk); uart_tx_ready = 1'b1;
        @(negedge clk);
        checks++; if (uart_tx_data !== 8'hA3) begin errors++; $display("FAIL pushpop_second got %h exp a3", uart_tx_data); end
        @(negedge clk); uart_tx_ready = 1'b0;
        checks++; if (uart_tx_valid !== 1'b0) begin errors++; $display("FAIL pushpop_empty got %b exp 0", uart_tx_valid); end

        for (int i = 0; i < 16; i++) do_write(16'hF000, 16'h0030 + 16'(i));
        @(negedge clk); wen = 1'b1; waddr = 16'hF000; wdata = 16'h00EE; uart_tx_ready = 1'b1;
        @(negedge clk); wen = 1'b0; uart_tx_ready = 1'b0;
        read1(16'hFFFB, v);
        checks++; if (v !== 16'h800F) begin errors++; $display("FAIL full_push_pop got %h exp 800f", v); end
        checks++; if (uart_tx_data !== 8'h31) begin errors++; $display("FAIL full_push_pop_head got %h exp 31", uart_tx_data); end
        do_write(16'hF000, 16'h0040);
        read_clr(v);
        @(negedge clk); wen = 1'b1; waddr = 16'hF000; wdata = 16'h0041; ren = 1'b1; raddr1 = 16'hFFFB;
        @(negedge clk); wen = 1'b0; ren = 1'b0;
        read1(16'hFFFB, v);
        checks++; if (v !== 16'h8010) begin errors++; $display("FAIL ovf_beats_clear got %h exp 8010", v); end
        @(negedge clk); uart_tx_ready = 1'b1;
        repeat (16) @(negedge clk);
        uart_tx_ready = 1'b0;
        checks++; if (uart_tx_valid !== 1'b0) begin errors++; $display("FAIL drain2_empty got %b exp 0", uart_tx_valid); end
        for (int i = 0; i < 5; i++) do_write(16'hF000, 16'h0050 + 16'(i));
    endtask

    task automatic test_ps2;
        int pulses;
        ps2_data_in = 16'h0041;
        @(negedge clk); ren = 1'b1; raddr1 = 16'hFFFF;
        @(negedge clk); ren = 1'b0;
        checks++; if (ps2_ren !== 1'b0) begin errors++; $display("FAIL ps2_early got %b exp 0", ps2_ren); end
        @(negedge clk);
        checks++; if (ps2_ren !== 1'b1 || rdata1 !== 16'h0041) begin errors++; $display("FAIL ps2_pulse got %b/%h exp 1/0041", ps2_ren, rdata1); end
        @(negedge clk);
        checks++; if (ps2_ren !== 1'b0) begin errors++; $display("FAIL ps2_one_cycle got %b exp 0", ps2_ren); end
        pulses = 0;
        repeat (4) begin
            @(negedge clk);
            if (ps2_ren === 1'b1) pulses++;
        end
        checks++; if (pulses != 0) begin errors++; $display("FAIL ps2_no_ren got %0d pulses exp 0", pulses); end
        raddr1 = 16'h0000;
    endtask

    task automatic test_reset_mid;
        logic [15:0] v;
        do_write(16'hFFFD, 16'h0200);
        @(negedge clk); raddr0 = 16'h0010;
        repeat (2) @(negedge clk);
        checks++; if (rdata0 !== 16'hABCD || uart_tx_valid !== 1'b1) begin errors++; $display("FAIL pre_reset got %h/%b exp abcd/1", rdata0, uart_tx_valid); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (uart_tx_valid !== 1'b0 || uart_tx_data !== 8'h00) begin errors++; $display("FAIL midrst_uart got %b/%h exp 0/00", uart_tx_valid, uart_tx_data); end
        checks++; if (rdata0 !== 16'h0 || rdata1 !== 16'h0 || pixel !== 12'h0) begin errors++; $display("FAIL midrst_outs got %h/%h/%h exp 0/0/0", rdata0, rdata1, pixel); end
        @(negedge clk); rst_n = 1'b1; wen = 1'b1; waddr = 16'h0020; wdata = 16'h5A5A;
        @(negedge clk); wen = 1'b0;
        read0(16'h0020, v);
        checks++; if (v !== 16'h5A5A) begin errors++; $display("FAIL first_write_after_rst got %h exp 5a5a", v); end
        read1(16'hFFFB, v);
        checks++; if (v !== 16'h0000) begin errors++; $display("FAIL status_after_rst got %h exp 0000", v); end
        read0(16'hFFFD, v);
        checks++; if (v !== 16'h0000) begin errors++; $display("FAIL hscroll_after_rst got %h exp 0000", v); end
        read0(16'h0010, v);
        checks++; if (v !== 16'hABCD) begin errors++; $display("FAIL ram_kept got %h exp abcd", v); end
        checks++; if (uart_tx_valid !== 1'b0) begin errors++; $display("FAIL fifo_discarded got %b exp 0", uart_tx_valid); end
    endtask

    initial begin
        test_reset();
        test_ram();
        test_display();
        test_uart();
        test_ps2();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
